native_rr_arbiter: RTL
======================

Name: native_rr_arbiter

Overview:
- Shares one native-interface slave (valid/ready/addr/wdata/wstrb/rdata) among N_MASTERS native masters using round-robin arbitration.
- Sits between several native-side requesters and the single native port. Typical requesters are an AXI4-Lite-to-native adapter and a local CPU/DMA port; the shared slave is an on-chip RAM or peripheral.
- Grant is held for exactly one transaction, ending with the slave's ready pulse. Priority then rotates.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- ADDR_WIDTH, 32, native address width.
- DATA_WIDTH, 32, native data width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width; all-zero means read.
- TIMEOUT_CYCLES, 255, slave-response timeout limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  N_MASTERS  per-master request valid.
- m_addr  in  N_MASTERS*ADDR_WIDTH  flat address bus; master i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wdata  in  N_MASTERS*DATA_WIDTH  flat write data.
- m_wstrb  in  N_MASTERS*STRB_WIDTH  flat write strobes.
- m_ready  out  N_MASTERS  per-master completion pulse.
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters; valid only for the master whose m_ready is high.
- s_valid  out  1  request to the shared slave.
- s_addr  out  ADDR_WIDTH  address to the slave.
- s_wdata  out  DATA_WIDTH  write data to the slave.
- s_wstrb  out  STRB_WIDTH  write strobes to the slave.
- s_ready  in  1  slave completion pulse.
- s_rdata  in  DATA_WIDTH  slave read data.
- grant  out  N_MASTERS  one-hot current owner; all zero when idle.
- timeout  out  1  one-cycle pulse on slave timeout; tied 0 without the optional feature.

Behaviour:
- States: IDLE, BUSY.
- Reset:
  - state=IDLE, grant=0, priority pointer ptr=0.
  - s_valid=0, m_ready=0, timeout=0.
  - s_addr, s_wdata, s_wstrb = 0.
- IDLE:
  - If any m_valid is high, select the first set bit searching upward from ptr, wrapping modulo N_MASTERS.
  - Register that one-hot selection into grant; go to BUSY next cycle.
  - s_valid=0 in IDLE. Arbitration latency is 1 cycle from m_valid to s_valid.
- BUSY:
  - s_valid = m_valid of the granted master.
  - s_addr, s_wdata, s_wstrb = the granted master's fields, muxed combinationally by grant.
  - Ungranted fields never reach the slave.
- Completion:
  - In BUSY, when s_ready=1: m_ready[granted] = s_ready (same cycle, combinational); m_rdata = s_rdata (always combinational pass-through).
  - Next cycle: ptr = granted index + 1 (wrap to 0 after N_MASTERS-1), grant=0, state=IDLE.
- Back-to-back: at least one IDLE cycle between transactions, so a single continuous requester gets at most one transaction per 2 cycles plus slave latency.
- Fairness: with all masters requesting, grants rotate 0,1,...,N-1,0. No master waits longer than N_MASTERS-1 other transactions.
- Granted master drops m_valid in BUSY before s_ready (protocol violation): s_valid falls, then return to IDLE next cycle. No m_ready pulse; ptr advances as if completed.
- s_ready while IDLE: ignored, no m_ready pulse.
- m_ready is never asserted to an ungranted master. At most one m_ready bit is high per cycle.
- Reset mid-transaction: immediate return to reset values at the next clock edge. The in-flight transaction is abandoned with no m_ready pulse.
- Requests arriving while BUSY wait; their m_valid must remain high until m_ready.

Optional Feature:
- Macro: NATIVE_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter (width = clog2(TIMEOUT_CYCLES+1)) clears on BUSY entry and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES, in that same cycle: force m_ready[granted]=1, m_rdata = all ones, timeout=1 for one cycle, s_valid deasserted.
  - Next cycle: IDLE, ptr advances.
  - A late s_ready arriving after timeout while IDLE is ignored.
- Undefined: no counter; timeout tied 0; BUSY waits indefinitely for s_ready.

Test Plan:
- Reset, then m_valid=2'b01, m_addr[0]=0x100, m_wstrb[0]=4'hF, m_wdata[0]=0xDEADBEEF, slave ready 2 cycles after s_valid -> s_valid rises cycle 1, s_addr=0x100, s_wdata=0xDEADBEEF, m_ready=2'b01 for one cycle, grant returns to 0.
- Both masters valid continuously, reads (wstrb=0), slave s_rdata=0xA5A5A5A5 with ready 1 cycle after valid -> grant sequence 01,10,01,10; each m_ready pulse goes only to the granted master; m_rdata=0xA5A5A5A5 on each pulse.
- N_MASTERS=4, masters 1 and 3 valid, ptr=2 after a master-1 completion -> master 3 granted first, then master 1.
- Granted master 0 drops m_valid after 1 BUSY cycle with s_ready=0 -> s_valid=0 that cycle, IDLE next cycle, no m_ready, master 1 granted next.
- rst asserted while BUSY with s_ready held 0 -> next cycle grant=0, s_valid=0, m_ready=0; a subsequent s_ready=1 produces no m_ready.
- With NATIVE_RR_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never readies -> m_ready[granted]=1, m_rdata=0xFFFFFFFF, timeout=1 on BUSY cycle 8; the next master is then granted.

Source files
------------

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native-interface slave among N_MASTERS masters.
// Optional slave-response timeout enabled by defining NATIVE_RR_ARBITER_TIMEOUT_EN.
module native_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             m_valid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    input  logic [N_MASTERS*STRB_WIDTH-1:0]  m_wstrb,
    output logic [N_MASTERS-1:0]             m_ready,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             s_valid,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [STRB_WIDTH-1:0]            s_wstrb,
    input  logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [N_MASTERS-1:0]             grant,
    output logic                             timeout
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    logic [N_MASTERS-1:0] grant_q;
    logic [PW-1:0]        ptr;
    logic [N_MASTERS-1:0] sel;
    logic [PW-1:0]        g_idx;
    logic [PW-1:0]        next_ptr;
    logic                 busy;
    logic                 granted_valid;
    logic                 timeout_hit;
    logic                 done;

    assign grant = grant_q;
    assign busy  = (state == BUSY);

    // Descending scan so the candidate closest to ptr (smallest offset) wins.
    always_comb begin
        logic [PW-1:0] ii;
        sel = '0;
        ii  = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            ii = PW'((int'(ptr) + k) % N_MASTERS);
            if (m_valid[ii]) begin
                sel     = '0;
                sel[ii] = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) g_idx = PW'(i);
        end
        next_ptr = (int'(g_idx) == N_MASTERS - 1) ? '0 : g_idx + PW'(1);
    end

    // Grant is zero while idle, so the one-hot mux also zeroes the slave fields.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign granted_valid = |(m_valid & grant_q);

`ifdef NATIVE_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            wait_cnt <= '0;
        end else if (!s_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = busy && granted_valid && !s_ready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign timeout = timeout_hit;
    assign s_valid = busy && granted_valid && !timeout_hit;
    assign m_ready = (busy && ((granted_valid && s_ready) || timeout_hit)) ? grant_q : '0;
    assign m_rdata = timeout_hit ? '1 : s_rdata;

    // A dropped request ends the transaction just like a completion does.
    assign done = busy && (!granted_valid || s_ready || timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        grant_q <= sel;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        grant_q <= '0;
                        ptr     <= next_ptr;
                        state   <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
